// File: rtl/oc_alloc_bankmap.sv
// Operand-collector allocator: grabs a free collector round-robin, maps sources to {bank,row}, issues reads.
// First beat is valid the cycle after accept (same-bank pairs take two beats); rd_* outputs hold while rd_ready is low.
module oc_alloc_bankmap #(
  parameter int NUM_OC        = 4,
  parameter int NUM_WARPS     = 8,
  parameter int REGS_PER_WARP = 8,
  parameter int NUM_BANKS     = 4,
  localparam int OC_W   = $clog2(NUM_OC),
  localparam int WARP_W = $clog2(NUM_WARPS),
  localparam int REG_W  = $clog2(REGS_PER_WARP),
  localparam int BANK_W = $clog2(NUM_BANKS),
  localparam int ROW_W  = $clog2(NUM_WARPS*REGS_PER_WARP/NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WARP_W-1:0] in_warp,
  input  logic [REG_W-1:0]  in_src_a,
  input  logic [REG_W-1:0]  in_src_b,
  input  logic              in_two_op,
  input  logic [NUM_OC-1:0] oc_release,
  output logic [NUM_OC-1:0] oc_busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [OC_W-1:0]   rd_ocid,
  output logic              rd_a_en,
  output logic              rd_b_en,
  output logic [BANK_W-1:0] rd_bank_a,
  output logic [BANK_W-1:0] rd_bank_b,
  output logic [ROW_W-1:0]  rd_row_a,
  output logic [ROW_W-1:0]  rd_row_b,
  output logic              rd_last
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_SEND_B = 2'd2} state_t;

  // Warp swizzle spreads the same register of consecutive warps across banks.
  function automatic logic [BANK_W-1:0] f_bank(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    logic [WARP_W+REG_W:0] s;
    s = {{(WARP_W+1){1'b0}}, r} + {{(REG_W+1){1'b0}}, w};
    return s[BANK_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] f_row(input logic [WARP_W-1:0] w, input logic [REG_W-1:0] r);
    return ROW_W'(w) * ROW_W'(REGS_PER_WARP/NUM_BANKS) + ROW_W'(r >> BANK_W);
  endfunction

  state_t              r_state, w_state_nxt;
  logic [NUM_OC-1:0]   r_busy;
  logic [OC_W-1:0]     r_rr_ptr;
  logic [BANK_W-1:0]   r_pend_bank;
  logic [ROW_W-1:0]    r_pend_row;
  logic                r_rd_valid, r_rd_a_en, r_rd_b_en, r_rd_last;
  logic [OC_W-1:0]     r_rd_ocid;
  logic [BANK_W-1:0]   r_rd_bank_a, r_rd_bank_b;
  logic [ROW_W-1:0]    r_rd_row_a, r_rd_row_b;

  logic                w_accept, w_found, w_conflict;
  logic [OC_W-1:0]     w_alloc_idx, w_cand;
  logic [NUM_OC-1:0]   w_set;
  logic [BANK_W-1:0]   w_bank_a, w_bank_b;
  logic [ROW_W-1:0]    w_row_a, w_row_b;

  assign w_bank_a   = f_bank(in_warp, in_src_a);
  assign w_bank_b   = f_bank(in_warp, in_src_b);
  assign w_row_a    = f_row(in_warp, in_src_a);
  assign w_row_b    = f_row(in_warp, in_src_b);
  assign w_conflict = in_two_op && (w_bank_a == w_bank_b);
  assign w_accept   = in_valid && in_ready;
  assign w_set      = w_accept ? (NUM_OC'(1) << w_alloc_idx) : '0;

  always_comb begin
    w_alloc_idx = r_rr_ptr;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < NUM_OC; k++) begin
      w_cand = r_rr_ptr + OC_W'(k);
      if (!w_found && !r_busy[w_cand]) begin
        w_alloc_idx = w_cand;
        w_found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SEND;
      S_SEND:   if (rd_ready) w_state_nxt = r_rd_last ? S_IDLE : S_SEND_B;
      S_SEND_B: if (rd_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE) && !(&r_busy);
  end

  // Set wins over release so a forced same-index collision never loses an allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= '0;
      r_rr_ptr    <= '0;
      r_pend_bank <= '0;
      r_pend_row  <= '0;
    end else begin
      r_busy <= (r_busy & ~oc_release) | w_set;
      if (w_accept) begin
        r_rr_ptr    <= w_alloc_idx + OC_W'(1);
        r_pend_bank <= w_bank_b;
        r_pend_row  <= w_row_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid  <= 1'b0;
      r_rd_ocid   <= '0;
      r_rd_a_en   <= 1'b0;
      r_rd_b_en   <= 1'b0;
      r_rd_bank_a <= '0;
      r_rd_bank_b <= '0;
      r_rd_row_a  <= '0;
      r_rd_row_b  <= '0;
      r_rd_last   <= 1'b0;
    end else if (w_accept) begin
      r_rd_valid  <= 1'b1;
      r_rd_ocid   <= w_alloc_idx;
      r_rd_a_en   <= 1'b1;
      r_rd_bank_a <= w_bank_a;
      r_rd_row_a  <= w_row_a;
      r_rd_b_en   <= in_two_op && !w_conflict;
      r_rd_bank_b <= (in_two_op && !w_conflict) ? w_bank_b : '0;
      r_rd_row_b  <= (in_two_op && !w_conflict) ? w_row_b : '0;
      r_rd_last   <= !w_conflict;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid  <= !r_rd_last;
      r_rd_ocid   <= r_rd_last ? '0 : r_rd_ocid;
      r_rd_a_en   <= 1'b0;
      r_rd_bank_a <= '0;
      r_rd_row_a  <= '0;
      r_rd_b_en   <= !r_rd_last;
      r_rd_bank_b <= r_rd_last ? '0 : r_pend_bank;
      r_rd_row_b  <= r_rd_last ? '0 : r_pend_row;
      r_rd_last   <= !r_rd_last;
    end
  end

  assign oc_busy   = r_busy;
  assign rd_valid  = r_rd_valid;
  assign rd_ocid   = r_rd_ocid;
  assign rd_a_en   = r_rd_a_en;
  assign rd_b_en   = r_rd_b_en;
  assign rd_bank_a = r_rd_bank_a;
  assign rd_bank_b = r_rd_bank_b;
  assign rd_row_a  = r_rd_row_a;
  assign rd_row_b  = r_rd_row_b;
  assign rd_last   = r_rd_last;

endmodule

// File: tb/tb_oc_alloc_bankmap.sv
// Directed bench for oc_alloc_bankmap: inputs change and outputs are sampled on the falling edge.
module tb_oc_alloc_bankmap;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_two_op;
  logic [2:0] in_warp, in_src_a, in_src_b;
  logic [3:0] oc_release, oc_busy;
  logic       rd_valid, rd_ready, rd_a_en, rd_b_en, rd_last;
  logic [1:0] rd_ocid, rd_bank_a, rd_bank_b;
  logic [3:0] rd_row_a, rd_row_b;

  int n_checks = 0;
  int n_fail   = 0;

  oc_alloc_bankmap dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_warp(in_warp), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_two_op(in_two_op),
    .oc_release(oc_release), .oc_busy(oc_busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ocid(rd_ocid),
    .rd_a_en(rd_a_en), .rd_b_en(rd_b_en),
    .rd_bank_a(rd_bank_a), .rd_bank_b(rd_bank_b),
    .rd_row_a(rd_row_a), .rd_row_b(rd_row_b), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [2:0] w, input logic [2:0] a, input logic [2:0] b, input logic two);
    in_valid = 1'b1; in_warp = w; in_src_a = a; in_src_b = b; in_two_op = two;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_warp = '0; in_src_a = '0; in_src_b = '0;
    in_two_op = 1'b0; oc_release = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", oc_busy, 4'b0000);
    chk("rst_fields", {rd_ocid, rd_a_en, rd_b_en, rd_bank_a, rd_bank_b, rd_row_a, rd_row_b, rd_last}, 0);

    // Two operands in different banks
    offer(3'd1, 3'd2, 3'd5, 1'b1); rd_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("nc_valid", rd_valid, 1);
    chk("nc_ocid", rd_ocid, 0);
    chk("nc_a", {rd_a_en, rd_bank_a, rd_row_a}, {1'b1, 2'd3, 4'd2});
    chk("nc_b", {rd_b_en, rd_bank_b, rd_row_b}, {1'b1, 2'd2, 4'd3});
    chk("nc_last", rd_last, 1);
    chk("nc_busy", oc_busy, 4'b0001);
    chk("nc_in_ready_busy", in_ready, 0);
    @(negedge clk);
    chk("nc_done", rd_valid, 0);
    chk("nc_in_ready", in_ready, 1);

    // Same-bank pair splits into two beats
    offer(3'd0, 3'd1, 3'd5, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("cf1_valid", rd_valid, 1);
    chk("cf1_ocid", rd_ocid, 1);
    chk("cf1_a", {rd_a_en, rd_bank_a, rd_row_a}, {1'b1, 2'd1, 4'd0});
    chk("cf1_b", {rd_b_en, rd_bank_b, rd_row_b}, 0);
    chk("cf1_last", rd_last, 0);
    @(negedge clk);
    chk("cf2_valid", rd_valid, 1);
    chk("cf2_ocid", rd_ocid, 1);
    chk("cf2_a", {rd_a_en, rd_bank_a, rd_row_a}, 0);
    chk("cf2_b", {rd_b_en, rd_bank_b, rd_row_b}, {1'b1, 2'd1, 4'd1});
    chk("cf2_last", rd_last, 1);
    chk("cf2_in_ready", in_ready, 0);
    @(negedge clk);
    chk("cf_done", rd_valid, 0);
    chk("cf_busy", oc_busy, 4'b0011);

    // Backpressure on a single-op beat
    rd_ready = 1'b0;
    offer(3'd2, 3'd3, 3'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {rd_valid, rd_ocid, rd_a_en, rd_b_en, rd_bank_a, rd_bank_b, rd_row_a, rd_row_b, rd_last},
          {1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 2'd0, 4'd4, 4'd0, 1'b1});
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("bp_still", rd_valid, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", rd_valid, 0);
    chk("bp_busy", oc_busy, 4'b0111);

    // Asynchronous reset while the second beat is pending
    offer(3'd3, 3'd0, 3'd4, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sb_beat1_ocid", rd_ocid, 3);
    @(negedge clk);
    chk("sb_in_send_b", {rd_valid, rd_b_en, rd_a_en}, 3'b110);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_busy", oc_busy, 4'b0000);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Fill all collectors round-robin
    for (int i = 0; i < 4; i++) begin
      offer(3'(i), 3'(i), 3'd0, 1'b0);
      chk("rr_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rr_ocid", rd_ocid, 32'(i));
      @(negedge clk);
    end
    chk("full_busy", oc_busy, 4'b1111);
    chk("full_in_ready", in_ready, 0);
    oc_release = 4'b0100;
    @(negedge clk);
    oc_release = 4'b0000;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", oc_busy, 4'b1011);
    offer(3'd5, 3'd6, 3'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rel_ocid", rd_ocid, 2);
    @(negedge clk);
    chk("refull_busy", oc_busy, 4'b1111);

    // Release and offer in the same cycle: accept lands one cycle later
    offer(3'd7, 3'd1, 3'd0, 1'b0);
    oc_release = 4'b0010;
    chk("same_in_ready", in_ready, 0);
    @(negedge clk);
    oc_release = 4'b0000;
    chk("same_no_accept", rd_valid, 0);
    chk("same_busy", oc_busy, 4'b1101);
    chk("same_in_ready2", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("same_ocid", {rd_valid, rd_ocid}, {1'b1, 2'd1});
    chk("same_bank", {rd_bank_a, rd_row_a}, {2'd0, 4'd14});
    @(negedge clk);
    chk("same_busy_end", oc_busy, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oc_alloc_bankmap.md
# oc_alloc_bankmap

Operand-collector allocator and register-bank mapper for the GPGPU operand-collector stage. It accepts decoded instructions from the issue unit, allocates a free operand collector round-robin, and maps the one or two source registers of the instruction to {bank, row} with a warp-swizzled arithmetic mapping, so no lookup table is needed. It then issues the operand read requests to the bank arbiter with a valid/ready handshake. When both operands fall in the same bank, it splits the request into two beats. Collector occupancy is tracked internally and cleared by per-collector release pulses.

## Interface
Parameters (all powers of two; REGS_PER_WARP ≥ NUM_BANKS):
- NUM_OC, 4, number of operand collectors
- NUM_WARPS, 8, hardware warps
- REGS_PER_WARP, 8, architectural registers per warp
- NUM_BANKS, 4, register-file banks
- Derived widths:
  - OC_W = log2(NUM_OC)
  - WARP_W = log2(NUM_WARPS)
  - REG_W = log2(REGS_PER_WARP)
  - BANK_W = log2(NUM_BANKS)
  - ROW_W = log2(NUM_WARPS*REGS_PER_WARP/NUM_BANKS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_warp  in  WARP_W  hardware warp id
- in_src_a  in  REG_W  source register A
- in_src_b  in  REG_W  source register B
- in_two_op  in  1  1: reads A and B; 0: reads A only
- oc_release  in  NUM_OC  bit i pulses to free collector i
- oc_busy  out  NUM_OC  collector occupancy
- rd_valid  out  1  read request valid
- rd_ready  in  1  bank arbiter accepts request
- rd_ocid  out  OC_W  destination collector
- rd_a_en / rd_b_en  out  1 each  operand A / B present in this beat
- rd_bank_a / rd_bank_b  out  BANK_W  bank of A / B
- rd_row_a / rd_row_b  out  ROW_W  row of A / B
- rd_last  out  1  final beat of this instruction

## Operation
- **Mapping:** for register r of warp w:
  - bank = (r + w) mod NUM_BANKS
  - row = w*(REGS_PER_WARP/NUM_BANKS) + r/NUM_BANKS
  - All arithmetic is truncating at the stated widths.
- **FSM states:**
  - IDLE: in_ready = 1 iff some oc_busy bit is 0. It is combinational from registered state only and has no path from in_valid or rd_ready.
  - SEND: the first (or only) beat is presented.
  - SEND_B: the second beat of a conflicting pair is presented.
- **Accept (IDLE, handshake):**
  - Latch warp, sources and two_op.
  - Pick the first free collector searching upward from rr_ptr, wrapping around.
  - Set its busy bit and set rr_ptr to the chosen index + 1 mod NUM_OC.
  - Go to SEND.
- **SEND beats:**
  - two_op=0: only A is present (a_en=1, b_en=0), last=1. On rd_ready go to IDLE.
  - two_op=1 and bank_a≠bank_b: A and B are both present, last=1. On rd_ready go to IDLE.
  - two_op=1 and bank_a=bank_b: only A is present, last=0. On rd_ready go to SEND_B.
- **SEND_B beat:** only B is present (a_en=0, b_en=1), last=1. On rd_ready go to IDLE.
- **Payload:** all rd_* outputs are registered. While rd_valid=1 && rd_ready=0 they hold stable. Fields whose enable is 0 are driven to 0.
- **Release:**
  - oc_release[i] clears busy[i] at the next edge.
  - Releasing a non-busy collector is ignored.
  - Allocation uses pre-edge busy, so a collector released this cycle is allocatable from the next cycle.
  - A release and an allocation of the same index in one cycle cannot occur, because only free collectors are allocated. If it is forced, the set wins.
- **Collectors full:** in IDLE with oc_busy all 1s, in_ready=0; the instruction waits.
- **Reset:**
  - Asynchronous, takes effect immediately, including mid-SEND or mid-SEND_B. The in-flight instruction is dropped.
  - Values during and after reset: state=IDLE, oc_busy=0, rr_ptr=0, rd_valid=0, all rd_* fields=0, in_ready=1.

## Timing
- Accept at edge N: rd_valid=1 in cycle N+1.
- Non-conflict instruction: one beat. Earliest next accept is the edge after the beat's handshake, giving throughput of 1 instruction per 2 cycles with rd_ready=1.
- Conflict instruction: two beats, minimum 3 cycles from accept to the next accept.
- oc_busy updates on the accept edge, visible in cycle N+1. A release pulse in cycle M is visible in M+1.

## Test plan
- **Reset:** hold rst=0 then release. Required: in_ready=1, rd_valid=0, oc_busy=0000. Assert rst=0 again mid-SEND_B: rd_valid and oc_busy go to 0 asynchronously, before the next clock edge.
- **Two operands, no conflict:** warp=1, src_a=2, src_b=5, two_op=1, rd_ready=1. Required: one beat with ocid=0, bank_a=3, row_a=2, bank_b=2, row_b=3, a_en=b_en=1, last=1; oc_busy=0001.
- **Bank conflict:** warp=0, src_a=1, src_b=5. Required:
  - beat 1: a_en=1, b_en=0, bank_a=1, row_a=0, last=0
  - beat 2: a_en=0, b_en=1, bank_b=1, row_b=1, last=1
  - both beats use the same ocid.
- **Backpressure:** hold rd_ready=0 for 3 cycles during SEND. Required: all rd_* fields stable and in_ready=0 throughout; advance only on the rd_ready=1 edge.
- **Full and round-robin:** perform 4 single-op accepts. Required: ocids 0, 1, 2, 3, then oc_busy=1111 and in_ready=0. Pulse oc_release=0100 for one cycle. Required: next cycle in_ready=1, and the next accept gets ocid=2.
- **Release/allocate same cycle:** busy=1111, pulse release bit 1 in the same cycle in_valid=1. Required: no accept that cycle; accept next cycle with ocid=1.
